// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: state encodings,
// default operand width and a helper for sizing the bit counter.
package serial_adder_pkg;

  // Operand width used when the instantiating design does not override it
  localparam int DEFAULT_WIDTH = 8;

  // Controller state encodings, kept as plain constants for legacy users
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bits needed to count 0..w-1; never less than one so WIDTH=1 still has
  // a real counter register
  function automatic int cnt_bits(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder, the only arithmetic element of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Classic sum / majority-carry equations
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller. Operands are captured on the accepting edge
// and consumed LSB first through one full_adder, one bit per RUN cycle. The
// assembled result and final carry are published on the edge entering DONE
// and then held until the next completed operation or reset.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW   = cnt_bits(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;
  logic             last_bit;

  // The one and only adder: current LSBs of both operands plus running carry
  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign last_bit = (cnt == LAST);

  // Result register shifted right with the fresh sum bit entering the MSB
  always_comb begin
    res_next            = res_sr >> 1;
    res_next[WIDTH-1]   = fa_s;
  end

  // Next-state decode; start only matters in IDLE, DONE always falls back
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (last_bit) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Serial datapath: capture operands on accept, shift one bit per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            carry  <= cin;
            cnt    <= '0;
          end
        end
        ST_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          carry  <= fa_c;
          cnt    <= cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Published result only changes on the edge that completes the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if ((state == ST_RUN) && last_bit) begin
      sum  <= res_next;
      cout <= fa_c;
    end
  end

  // Status flags come straight from the state register
  always_comb begin
    busy = (state == ST_RUN) || (state == ST_DONE);
    done = (state == ST_DONE);
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;

  typedef struct {
    logic [7:0] s;
    logic       c;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start8, start1;
  logic [7:0] a8, b8;
  logic [0:0] a1, b1;
  logic       cin8, cin1;
  logic       busy8, done8, cout8;
  logic       busy1, done1, cout1;
  logic [7:0] sum8;
  logic [0:0] sum1;

  exp_t q8[$];
  exp_t q1[$];
  int   cyc;
  int   checks;
  int   errors;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  // Free-running clock and edge counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Drive one operation at a falling edge; expected result and done cycle go
  // into the scoreboard. keep leaves start high for back-to-back use.
  task automatic applyStimulus(input bit w1, input logic [7:0] av, input logic [7:0] bv,
                               input logic cv, input logic [7:0] s_exp, input logic c_exp,
                               input bit keep);
    exp_t e;
    @(negedge clk);
    e.s = s_exp;
    e.c = c_exp;
    if (w1) begin
      a1 = av[0:0]; b1 = bv[0:0]; cin1 = cv; start1 = 1'b1;
      e.cyc = cyc + 1 + 1;
      q1.push_back(e);
    end else begin
      a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
      e.cyc = cyc + 1 + 8;
      q8.push_back(e);
    end
    if (!keep) begin
      @(negedge clk);
      start8 = 1'b0;
      start1 = 1'b0;
    end
  endtask

  // Wait, with a bound, for every expected result to have been seen
  task automatic waitDrain();
    int n;
    n = 0;
    while ((q8.size() != 0 || q1.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_pending", q8.size() + q1.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Monitor for the 8-bit instance: every done pulse must match the queue head
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        checkOutput("w8_unexpected_done", 1, 0);
      end else begin
        e = q8.pop_front();
        checkOutput("w8_sum", sum8, e.s);
        checkOutput("w8_cout", cout8, e.c);
        checkOutput("w8_done_cycle", cyc, e.cyc);
      end
    end
  end

  // Monitor for the 1-bit instance
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done1) begin
      if (q1.size() == 0) begin
        checkOutput("w1_unexpected_done", 1, 0);
      end else begin
        e = q1.pop_front();
        checkOutput("w1_sum", sum1, e.s[0:0]);
        checkOutput("w1_cout", cout1, e.c);
        checkOutput("w1_done_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    cyc = 0; checks = 0; errors = 0;
    rst_n = 1'b0;
    start8 = 1'b0; start1 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0;
    a1 = '0; b1 = '0; cin1 = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_w8_outputs", {busy8, done8, cout8, sum8}, 0);
    checkOutput("rst_w1_outputs", {busy1, done1, cout1, sum1}, 0);
    rst_n = 1'b1;

    // Carry ripples all the way out
    applyStimulus(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    waitDrain();

    // Operands scrambled during RUN must not matter; sum held meanwhile
    applyStimulus(1'b0, 8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, 1'b0);
    checkOutput("run_busy", busy8, 1);
    for (int i = 0; i < 6; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      @(negedge clk);
      if (i == 2) checkOutput("run_sum_hold", {cout8, sum8}, 9'h100);
    end
    waitDrain();

    // Start re-pulsed three cycles into RUN is ignored
    applyStimulus(1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    start8 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF;
    @(negedge clk);
    start8 = 1'b0;
    waitDrain();

    // Reset during RUN aborts without a done pulse
    applyStimulus(1'b0, 8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_w8_outputs", {busy8, done8, cout8, sum8}, 0);
    q8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h81, 8'h7F, 1'b0, 8'h00, 1'b1, 1'b0);
    waitDrain();

    // Start held high: one result every WIDTH+2 cycles
    applyStimulus(1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    applyStimulus(1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    repeat (9) @(negedge clk);
    applyStimulus(1'b0, 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0);
    waitDrain();

    // Single-bit instance
    applyStimulus(1'b1, 8'h01, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0);
    waitDrain();
    applyStimulus(1'b1, 8'h00, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0);
    waitDrain();
    checkOutput("w1_idle_hold", {busy1, cout1, sum1}, 3'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time guard
  initial begin
    #200000;
    $display("[TB] FAIL timeout got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
